// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes requests into ALU select codes, holds the ALU inputs for LAT cycles, returns the result.
// Optional macro ALU_STATS_EN adds saturating op_count / carry_count response statistics ports.
module alu_issue_ctrl #(
   parameter int LAT   = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [5:0]       req_op,
   input  logic [5:0]       req_funct,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [1:0]       alu_sel,
   input  logic [31:0]      alu_out,
   input  logic             alu_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic             rsp_carry,
   output logic             rsp_err
`ifdef ALU_STATS_EN
   ,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] carry_count
`endif
);

   // Both channels transfer on a rising clk edge with valid && ready high; the sender keeps
   // its payload stable from valid rising until that edge, and ready never waits on valid.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam logic [1:0] WAIT_INIT = 2'(LAT - 1);

   if (LAT < 1 || LAT > 4 || CNT_W < 1) begin : g_param_check
      $error("alu_issue_ctrl: LAT must be 1..4 and CNT_W must be at least 1");
   end

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] alu_a_q, alu_a_d;
   logic [31:0] alu_b_q, alu_b_d;
   logic [1:0]  alu_sel_q, alu_sel_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_result_q, rsp_result_d;
   logic        rsp_carry_q, rsp_carry_d;
   logic        rsp_err_q, rsp_err_d;
   logic [1:0]  dec_sel;
   logic        dec_legal;
   logic        rsp_fire;

   always_comb begin
      dec_sel   = 2'b00;
      dec_legal = 1'b1;
      case (req_op)
         6'h00: begin
            case (req_funct)
               6'h20:   dec_sel = 2'b00;
               6'h24:   dec_sel = 2'b01;
               6'h25:   dec_sel = 2'b10;
               default: dec_legal = 1'b0;
            endcase
         end
         6'h08, 6'h23, 6'h2B: dec_sel = 2'b00;
         6'h04:               dec_sel = 2'b11;
         default:             dec_legal = 1'b0;
      endcase
   end

   assign rsp_fire  = rsp_valid_q & rsp_ready;
   assign req_ready = (state_q == S_IDLE);

   // rsp_valid is registered off the RESP state, so it rises one edge after RESP is entered.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_sel_d    = alu_sel_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (dec_legal) begin
                  alu_a_d   = req_a;
                  alu_b_d   = req_b;
                  alu_sel_d = dec_sel;
                  cnt_d     = WAIT_INIT;
                  state_d   = S_EXEC;
               end else begin
                  rsp_result_d = 32'h0;
                  rsp_carry_d  = 1'b0;
                  rsp_err_d    = 1'b1;
                  state_d      = S_RESP;
               end
            end
         end
         S_EXEC: begin
            if (cnt_q == 2'd0) begin
               rsp_result_d = alu_out;
               rsp_carry_d  = alu_cout;
               rsp_err_d    = 1'b0;
               state_d      = S_RESP;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         S_RESP: begin
            rsp_valid_d = 1'b1;
            if (rsp_fire) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

`ifdef ALU_STATS_EN
   logic [CNT_W-1:0] op_count_q, op_count_d;
   logic [CNT_W-1:0] carry_count_q, carry_count_d;

   always_comb begin
      op_count_d    = op_count_q;
      carry_count_d = carry_count_q;
      if (rsp_fire) begin
         if (op_count_q != '1) op_count_d = op_count_q + 1'b1;
         if (rsp_carry_q && (carry_count_q != '1)) carry_count_d = carry_count_q + 1'b1;
      end
   end

   assign op_count    = op_count_q;
   assign carry_count = carry_count_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= 2'd0;
         alu_a_q       <= 32'h0;
         alu_b_q       <= 32'h0;
         alu_sel_q     <= 2'b00;
         rsp_valid_q   <= 1'b0;
         rsp_result_q  <= 32'h0;
         rsp_carry_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
`ifdef ALU_STATS_EN
         op_count_q    <= '0;
         carry_count_q <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_sel_q     <= alu_sel_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_result_q  <= rsp_result_d;
         rsp_carry_q   <= rsp_carry_d;
         rsp_err_q     <= rsp_err_d;
`ifdef ALU_STATS_EN
         op_count_q    <= op_count_d;
         carry_count_q <= carry_count_d;
`endif
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_sel    = alu_sel_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_carry  = rsp_carry_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: lane 0 runs LAT=1, lane 1 runs LAT=3, each with its own behavioural ALU.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

   localparam int CNT_W = 4;
   localparam int SAT   = 15;
   localparam int LATS [2] = '{1, 3};

   logic clk = 1'b0;
   logic rst;
   logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready, rsp_carry, rsp_err, alu_cout;
   logic [1:0][5:0]  req_op, req_funct;
   logic [1:0][31:0] req_a, req_b, alu_a, alu_b, alu_out, rsp_result;
   logic [1:0][1:0]  alu_sel;
`ifdef ALU_STATS_EN
   logic [1:0][CNT_W-1:0] op_count, carry_count;
   int ops_m [2];
   int cars_m [2];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_lane
      logic [32:0] sum;
      alu_issue_ctrl #(.LAT(g == 0 ? 1 : 3), .CNT_W(CNT_W)) dut (
         .clk(clk), .rst(rst),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]),
         .req_op(req_op[g]), .req_funct(req_funct[g]),
         .req_a(req_a[g]), .req_b(req_b[g]),
         .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_sel(alu_sel[g]),
         .alu_out(alu_out[g]), .alu_cout(alu_cout[g]),
         .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
         .rsp_result(rsp_result[g]), .rsp_carry(rsp_carry[g]), .rsp_err(rsp_err[g])
`ifdef ALU_STATS_EN
         , .op_count(op_count[g]), .carry_count(carry_count[g])
`endif
      );
      // Behavioural ALU: carry-out is always the carry of A+B.
      assign sum         = {1'b0, alu_a[g]} + {1'b0, alu_b[g]};
      assign alu_cout[g] = sum[32];
      assign alu_out[g]  = (alu_sel[g] == 2'b00) ? sum[31:0] :
                           (alu_sel[g] == 2'b01) ? (alu_a[g] & alu_b[g]) :
                           (alu_sel[g] == 2'b10) ? (alu_a[g] | alu_b[g]) : {alu_a[g][29:0], 2'b00};
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_cyc [2];
   int exp_lat [2];
   int rdy_mode [2];
   logic [1:0][31:0] last_a, last_b;
   logic [1:0][1:0]  last_sel;
   logic [33:0] exp_q0[$];
   logic [33:0] exp_q1[$];

   function automatic void check(input string name, input int l, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s lane%0d: got %0h expected %0h (t=%0t)", name, l, act, exp, $time);
      end
   endfunction

   function automatic void q_push(input int l, input logic [33:0] v);
      if (l == 0) exp_q0.push_back(v);
      else exp_q1.push_back(v);
   endfunction

   function automatic int q_size(input int l);
      return (l == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic logic [33:0] q_pop(input int l);
      if (l == 0) return exp_q0.pop_front();
      return exp_q1.pop_front();
   endfunction

   // Reference: {err, carry, result} straight from the instruction semantics.
   function automatic void ref_model(input logic [5:0] op, input logic [5:0] funct,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [33:0] rsp, output logic legal, output logic [1:0] sel);
      logic [32:0] s;
      logic [31:0] res;
      s     = {1'b0, a} + {1'b0, b};
      legal = 1'b1;
      sel   = 2'b00;
      res   = s[31:0];
      if (op == 6'h00) begin
         case (funct)
            6'h20: res = s[31:0];
            6'h24: begin sel = 2'b01; res = a & b; end
            6'h25: begin sel = 2'b10; res = a | b; end
            default: legal = 1'b0;
         endcase
      end else if (op == 6'h04) begin
         sel = 2'b11;
         res = a * 32'd4;
      end else if (op != 6'h08 && op != 6'h23 && op != 6'h2B) begin
         legal = 1'b0;
      end
      rsp = legal ? {1'b0, s[32], res} : {2'b10, 32'h0};
   endfunction

   task automatic drive_req(input int l, input logic [5:0] op, input logic [5:0] funct,
                            input logic [31:0] a, input logic [31:0] b);
      logic [33:0] e;
      logic        legal;
      logic [1:0]  sel;
      int          waited;
      ref_model(op, funct, a, b, e, legal, sel);
      @(negedge clk);
      req_op[l] = op; req_funct[l] = funct; req_a[l] = a; req_b[l] = b;
      req_valid[l] = 1'b1;
      waited = 0;
      while (!req_ready[l] && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check("req_accept_timeout", l, 64'(waited >= 100), 64'(0));
      if (waited >= 100) begin
         req_valid[l] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid[l] = 1'b0;
      acc_cyc[l] = cyc;
      exp_lat[l] = legal ? LATS[l] + 1 : 1;
      q_push(l, e);
      if (legal) begin
         last_a[l] = a; last_b[l] = b; last_sel[l] = sel;
      end
      check("alu_a", l, 64'(alu_a[l]), 64'(last_a[l]));
      check("alu_b", l, 64'(alu_b[l]), 64'(last_b[l]));
      check("alu_sel", l, 64'(alu_sel[l]), 64'(last_sel[l]));
   endtask

   task automatic rand_ops(input int l, input int n);
      logic [5:0]  op, funct;
      logic [31:0] a, b;
      for (int i = 0; i < n; i++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFF;
         funct = 6'($urandom_range(0, 63));
         op = 6'h00;
         case ($urandom_range(0, 8))
            0: funct = 6'h20;
            1: funct = 6'h24;
            2: funct = 6'h25;
            3: op = 6'h08;
            4: op = 6'h23;
            5: op = 6'h2B;
            6: op = 6'h04;
            7: op = 6'($urandom_range(1, 63));
            default: op = 6'h00;
         endcase
         drive_req(l, op, funct, a, b);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
   endtask

   task automatic wait_idle(input int l);
      int n;
      n = 0;
      while ((q_size(l) != 0 || rsp_valid[l]) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", l, 64'(n >= 300), 64'(0));
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      rsp_ready = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int l = 0; l < 2; l++) begin
            case (rdy_mode[l])
               0:       rsp_ready[l] = 1'($urandom_range(0, 1));
               1:       rsp_ready[l] = 1'b0;
               default: rsp_ready[l] = 1'b1;
            endcase
         end
      end
   end

   logic [1:0]       prev_v;
   logic [1:0][33:0] held;
   logic [33:0]      mon_cur, mon_exp;

   always @(negedge clk) begin
      for (int l = 0; l < 2; l++) begin
         if (rst) begin
            prev_v[l] = 1'b0;
`ifdef ALU_STATS_EN
            ops_m[l]  = 0;
            cars_m[l] = 0;
`endif
         end else begin
`ifdef ALU_STATS_EN
            check("op_count", l, 64'(op_count[l]), 64'(ops_m[l]));
            check("carry_count", l, 64'(carry_count[l]), 64'(cars_m[l]));
`endif
            mon_cur = {rsp_err[l], rsp_carry[l], rsp_result[l]};
            if (rsp_valid[l]) begin
               check("req_ready_while_rsp", l, 64'(req_ready[l]), 64'(0));
               if (!prev_v[l]) begin
                  if (q_size(l) == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL unexpected_rsp lane%0d: got rsp_valid=1 expected no response (t=%0t)", l, $time);
                  end else begin
                     check("latency", l, 64'(cyc - acc_cyc[l]), 64'(exp_lat[l]));
                  end
               end else begin
                  check("rsp_stable", l, 64'(mon_cur), 64'(held[l]));
               end
               held[l] = mon_cur;
               if (rsp_ready[l]) begin
                  if (q_size(l) != 0) begin
                     mon_exp = q_pop(l);
                     check("rsp_data", l, 64'(mon_cur), 64'(mon_exp));
                  end
`ifdef ALU_STATS_EN
                  if (ops_m[l] < SAT) ops_m[l]++;
                  if (mon_cur[32] && cars_m[l] < SAT) cars_m[l]++;
`endif
               end
            end
            prev_v[l] = rsp_valid[l] & ~rsp_ready[l];
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish within 500us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      req_valid = '0; req_op = '0; req_funct = '0; req_a = '0; req_b = '0;
      last_a = '0; last_b = '0; last_sel = '0;
      rdy_mode[0] = 2; rdy_mode[1] = 2;
      repeat (3) @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++) begin
         check("rst_rsp_valid", l, 64'(rsp_valid[l]), 64'(0));
         check("rst_req_ready", l, 64'(req_ready[l]), 64'(1));
         check("rst_alu_sel", l, 64'(alu_sel[l]), 64'(0));
         check("rst_alu_a", l, 64'(alu_a[l]), 64'(0));
         check("rst_alu_b", l, 64'(alu_b[l]), 64'(0));
         check("rst_rsp", l, 64'({rsp_err[l], rsp_carry[l], rsp_result[l]}), 64'(0));
      end
      @(negedge clk);
      rst = 1'b0;

      drive_req(0, 6'h00, 6'h20, 32'hFFFF_FFFF, 32'h0000_0001);
      drive_req(0, 6'h00, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00);
      drive_req(0, 6'h00, 6'h25, 32'hF0F0_F0F0, 32'hFF00_FF00);
      drive_req(0, 6'h04, 6'h00, 32'h0000_0003, 32'h0000_0000);
      wait_idle(0);

      rdy_mode[0] = 1;
      drive_req(0, 6'h08, 6'h11, 32'h8000_1234, 32'h8000_0010);
      repeat (8) @(posedge clk);
      rdy_mode[0] = 2;
      drive_req(0, 6'h3F, 6'h00, 32'hDEAD_BEEF, 32'h1234_5678);
      wait_idle(0);

      rdy_mode[0] = 0; rdy_mode[1] = 0;
      fork
         rand_ops(0, 40);
         rand_ops(1, 30);
      join
      rdy_mode[0] = 2; rdy_mode[1] = 2;
      wait_idle(0);
      wait_idle(1);

      drive_req(1, 6'h00, 6'h20, 32'h0000_0001, 32'h0000_0002);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midop_rsp_valid", 1, 64'(rsp_valid[1]), 64'(0));
      check("midop_req_ready", 1, 64'(req_ready[1]), 64'(1));
      check("midop_alu_sel", 1, 64'(alu_sel[1]), 64'(0));
      check("midop_alu_a", 1, 64'(alu_a[1]), 64'(0));
      exp_q0.delete();
      exp_q1.delete();
      last_a = '0; last_b = '0; last_sel = '0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abandoned_no_rsp", 1, 64'(rsp_valid[1]), 64'(0));
      end
      drive_req(1, 6'h00, 6'h20, 32'h0000_0005, 32'h0000_0007);
      wait_idle(1);
      @(negedge clk);
`ifdef ALU_STATS_EN
      check("final_op_count", 1, 64'(op_count[1]), 64'(1));
      check("final_carry_count", 1, 64'(carry_count[1]), 64'(0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
